// File: rtl/decode_issue_unit_pkg.sv
// decode_issue_unit_pkg: op-type enum and RV32I opcode constants shared by the decode/issue stage.
package decode_issue_unit_pkg;
   typedef enum logic [5:0] {
      OP_NONE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
   } op_t;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_REG    = 7'b0110011;
endpackage

// File: rtl/decode_issue_unit_inst_queue.sv
// decode_issue_unit_inst_queue: circular FIFO of {pc, inst} pairs with an occupancy count.
module decode_issue_unit_inst_queue #(
   parameter int DEPTH = 8,
   parameter int W = 32
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           pc_in,
   input  logic [W-1:0]           inst_in,
   output logic                   ready,
   output logic [W-1:0]           pc,
   output logic [W-1:0]           inst,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] pc_mem [DEPTH];
   logic [W-1:0] inst_mem [DEPTH];
   logic [AW-1:0] head, tail;
   assign ready = count < (AW+1)'(DEPTH);
   assign pc = pc_mem[head];
   assign inst = inst_mem[head];
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         if (push) begin
            pc_mem[tail] <= pc_in;
            inst_mem[tail] <= inst_in;
            tail <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/decode_issue_unit.sv
// decode_issue_unit: queued RV32I decode, operand resolution and registered issue to RS/LSB/ROB.
// Optional CDB_BYPASS_EN: pending operands also capture a matching same-cycle CDB broadcast.
module decode_issue_unit
   import decode_issue_unit_pkg::*;
#(
   parameter int IQ_DEPTH = 8,
   parameter int TAG_W = 4,
   parameter int OP_W = 6,
   parameter int XLEN = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             clear_in,
   input  logic             if_valid_in,
   output logic             if_ready_out,
   input  logic [XLEN-1:0]  if_inst_in,
   input  logic [XLEN-1:0]  if_pc_in,
   output logic [4:0]       reg_rs1_out,
   output logic [4:0]       reg_rs2_out,
   input  logic [XLEN-1:0]  reg_rs1_data_in,
   input  logic [XLEN-1:0]  reg_rs2_data_in,
   input  logic [TAG_W-1:0] reg_rs1_tag_in,
   input  logic [TAG_W-1:0] reg_rs2_tag_in,
   output logic [TAG_W-1:0] rob_q1_out,
   output logic [TAG_W-1:0] rob_q2_out,
   input  logic             rob_v1_ready_in,
   input  logic             rob_v2_ready_in,
   input  logic [XLEN-1:0]  rob_v1_data_in,
   input  logic [XLEN-1:0]  rob_v2_data_in,
   input  logic             rob_full_in,
   input  logic [TAG_W-1:0] rob_tag_in,
   input  logic             rs_full_in,
   input  logic             lsb_full_in,
   input  logic             cdb_valid_in,
   input  logic [TAG_W-1:0] cdb_tag_in,
   input  logic [XLEN-1:0]  cdb_data_in,
   output logic             rob_valid_out,
   output logic             rs_valid_out,
   output logic             lsb_valid_out,
   output logic [4:0]       rob_rd_out,
   output logic             ren_valid_out,
   output logic [4:0]       ren_rd_out,
   output logic [TAG_W-1:0] ren_tag_out,
   output logic [OP_W-1:0]  iss_op_out,
   output logic [TAG_W-1:0] iss_dest_out,
   output logic [TAG_W-1:0] iss_qj_out,
   output logic [XLEN-1:0]  iss_vj_out,
   output logic [TAG_W-1:0] iss_qk_out,
   output logic [XLEN-1:0]  iss_vk_out,
   output logic [XLEN-1:0]  iss_imm_out,
   output logic [XLEN-1:0]  iss_pc_out
);
   logic [$clog2(IQ_DEPTH):0] count;
   logic [XLEN-1:0] inst, pc, imm, imm_i, imm_s, imm_b, imm_u, imm_j, vj, vk;
   logic [TAG_W-1:0] qj, qk;
   logic [2:0] f3;
   logic [4:0] rd;
   logic push, fire, iss, use1, use2, shimm, wr, mem, ren;
   op_t op;
   decode_issue_unit_inst_queue #(.DEPTH(IQ_DEPTH), .W(XLEN)) inst_queue (
      .clk_in(clk_in), .rst_in(rst_in || clear_in), .push(push), .pop(fire),
      .pc_in(if_pc_in), .inst_in(if_inst_in), .ready(if_ready_out),
      .pc(pc), .inst(inst), .count(count)
   );
   assign push = rdy_in && if_valid_in && if_ready_out;
   assign f3 = inst[14:12];
   assign rd = inst[11:7];
   assign reg_rs1_out = inst[19:15];
   assign reg_rs2_out = inst[24:20];
   assign rob_q1_out = reg_rs1_tag_in;
   assign rob_q2_out = reg_rs2_tag_in;
   assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
   assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
   assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   always_comb begin
      op = OP_NONE;
      imm = '0;
      use1 = 1'b0;
      use2 = 1'b0;
      shimm = 1'b0;
      wr = 1'b0;
      mem = 1'b0;
      case (inst[6:0])
         OPC_LUI: begin op = OP_LUI; imm = imm_u; wr = 1'b1; end
         OPC_AUIPC: begin op = OP_AUIPC; imm = imm_u; wr = 1'b1; end
         OPC_JAL: begin op = OP_JAL; imm = imm_j; wr = 1'b1; end
         OPC_JALR: begin op = f3 == 3'd0 ? OP_JALR : OP_NONE; imm = imm_i; use1 = 1'b1; wr = 1'b1; end
         OPC_BRANCH: begin
            case (f3)
               3'd0: op = OP_BEQ;
               3'd1: op = OP_BNE;
               3'd4: op = OP_BLT;
               3'd5: op = OP_BGE;
               3'd6: op = OP_BLTU;
               3'd7: op = OP_BGEU;
               default: op = OP_NONE;
            endcase
            imm = imm_b;
            use1 = 1'b1;
            use2 = 1'b1;
         end
         OPC_LOAD: begin
            case (f3)
               3'd0: op = OP_LB;
               3'd1: op = OP_LH;
               3'd2: op = OP_LW;
               3'd4: op = OP_LBU;
               3'd5: op = OP_LHU;
               default: op = OP_NONE;
            endcase
            imm = imm_i;
            use1 = 1'b1;
            wr = 1'b1;
            mem = 1'b1;
         end
         OPC_STORE: begin
            op = f3 == 3'd0 ? OP_SB : f3 == 3'd1 ? OP_SH : f3 == 3'd2 ? OP_SW : OP_NONE;
            imm = imm_s;
            use1 = 1'b1;
            use2 = 1'b1;
            mem = 1'b1;
         end
         OPC_IMM: begin
            case (f3)
               3'd0: op = OP_ADDI;
               3'd1: op = OP_SLLI;
               3'd2: op = OP_SLTI;
               3'd3: op = OP_SLTIU;
               3'd4: op = OP_XORI;
               3'd5: op = inst[30] ? OP_SRAI : OP_SRLI;
               3'd6: op = OP_ORI;
               default: op = OP_ANDI;
            endcase
            imm = imm_i;
            use1 = 1'b1;
            wr = 1'b1;
            shimm = f3 == 3'd1 || f3 == 3'd5;
         end
         OPC_REG: begin
            case (f3)
               3'd0: op = inst[30] ? OP_SUB : OP_ADD;
               3'd1: op = OP_SLL;
               3'd2: op = OP_SLT;
               3'd3: op = OP_SLTU;
               3'd4: op = OP_XOR;
               3'd5: op = inst[30] ? OP_SRA : OP_SRL;
               3'd6: op = OP_OR;
               default: op = OP_AND;
            endcase
            use1 = 1'b1;
            use2 = 1'b1;
            wr = 1'b1;
         end
         default: ;
      endcase
   end
   always_comb begin
      qj = (reg_rs1_tag_in == '0 || rob_v1_ready_in) ? '0 : reg_rs1_tag_in;
      vj = reg_rs1_tag_in == '0 ? reg_rs1_data_in : rob_v1_ready_in ? rob_v1_data_in : '0;
      qk = (reg_rs2_tag_in == '0 || rob_v2_ready_in) ? '0 : reg_rs2_tag_in;
      vk = reg_rs2_tag_in == '0 ? reg_rs2_data_in : rob_v2_ready_in ? rob_v2_data_in : '0;
`ifdef CDB_BYPASS_EN
      if (cdb_valid_in && qj != '0 && qj == cdb_tag_in) begin
         qj = '0;
         vj = cdb_data_in;
      end
      if (cdb_valid_in && qk != '0 && qk == cdb_tag_in) begin
         qk = '0;
         vk = cdb_data_in;
      end
`endif
      if (!use1) begin
         qj = '0;
         vj = '0;
      end
      if (shimm) begin
         qk = '0;
         vk = XLEN'(inst[24:20]);
      end else if (!use2) begin
         qk = '0;
         vk = '0;
      end
   end
`ifndef CDB_BYPASS_EN
   logic unused_cdb;
   assign unused_cdb = ^{cdb_valid_in, cdb_tag_in, cdb_data_in};
`endif
   // Unknown encodings still pop (fire) but never reach the back end (iss).
   assign fire = rdy_in && !clear_in && count != '0 && !rob_full_in && !(mem ? lsb_full_in : rs_full_in);
   assign iss = fire && op != OP_NONE;
   assign ren = wr && rd != 5'd0;
   always_ff @(posedge clk_in) begin
      if (rst_in || clear_in) begin
         {rob_valid_out, rs_valid_out, lsb_valid_out, ren_valid_out} <= '0;
         {rob_rd_out, ren_rd_out, ren_tag_out, iss_op_out, iss_dest_out} <= '0;
         {iss_qj_out, iss_vj_out, iss_qk_out, iss_vk_out, iss_imm_out, iss_pc_out} <= '0;
      end else begin
         rob_valid_out <= iss;
         rs_valid_out <= iss && !mem;
         lsb_valid_out <= iss && mem;
         ren_valid_out <= iss && ren;
         if (iss) begin
            rob_rd_out <= wr ? rd : 5'd0;
            ren_rd_out <= ren ? rd : 5'd0;
            ren_tag_out <= ren ? rob_tag_in : '0;
            iss_op_out <= OP_W'(op);
            iss_dest_out <= rob_tag_in;
            iss_qj_out <= qj;
            iss_vj_out <= vj;
            iss_qk_out <= qk;
            iss_vk_out <= vk;
            iss_imm_out <= imm;
            iss_pc_out <= pc;
         end
      end
   end
endmodule

// File: tb/tb_decode_issue_unit.sv
// tb_decode_issue_unit: directed vectors with a scoreboard queue checked by an issue monitor.
module tb_decode_issue_unit;
   import decode_issue_unit_pkg::*;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, rdy_in, clear_in, if_valid_in, if_ready_out;
   logic [31:0] if_inst_in, if_pc_in;
   logic [4:0] reg_rs1_out, reg_rs2_out;
   logic [31:0] reg_rs1_data_in, reg_rs2_data_in, rob_v1_data_in, rob_v2_data_in, cdb_data_in;
   logic [3:0] reg_rs1_tag_in, reg_rs2_tag_in, rob_q1_out, rob_q2_out, rob_tag_in, cdb_tag_in;
   logic rob_v1_ready_in, rob_v2_ready_in, rob_full_in, rs_full_in, lsb_full_in, cdb_valid_in;
   logic rob_valid_out, rs_valid_out, lsb_valid_out, ren_valid_out;
   logic [4:0] rob_rd_out, ren_rd_out;
   logic [3:0] ren_tag_out, iss_dest_out, iss_qj_out, iss_qk_out;
   logic [5:0] iss_op_out;
   logic [31:0] iss_vj_out, iss_vk_out, iss_imm_out, iss_pc_out;
   logic [31:0] rf_val [32];
   logic [3:0] rf_tag [32];
   logic rob_rdy [16];
   logic [31:0] rob_dat [16];
   assign reg_rs1_data_in = rf_val[reg_rs1_out];
   assign reg_rs2_data_in = rf_val[reg_rs2_out];
   assign reg_rs1_tag_in = rf_tag[reg_rs1_out];
   assign reg_rs2_tag_in = rf_tag[reg_rs2_out];
   assign rob_v1_ready_in = rob_rdy[rob_q1_out];
   assign rob_v2_ready_in = rob_rdy[rob_q2_out];
   assign rob_v1_data_in = rob_dat[rob_q1_out];
   assign rob_v2_data_in = rob_dat[rob_q2_out];
   decode_issue_unit dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy_in), .clear_in(clear_in),
      .if_valid_in(if_valid_in), .if_ready_out(if_ready_out), .if_inst_in(if_inst_in), .if_pc_in(if_pc_in),
      .reg_rs1_out(reg_rs1_out), .reg_rs2_out(reg_rs2_out),
      .reg_rs1_data_in(reg_rs1_data_in), .reg_rs2_data_in(reg_rs2_data_in),
      .reg_rs1_tag_in(reg_rs1_tag_in), .reg_rs2_tag_in(reg_rs2_tag_in),
      .rob_q1_out(rob_q1_out), .rob_q2_out(rob_q2_out),
      .rob_v1_ready_in(rob_v1_ready_in), .rob_v2_ready_in(rob_v2_ready_in),
      .rob_v1_data_in(rob_v1_data_in), .rob_v2_data_in(rob_v2_data_in),
      .rob_full_in(rob_full_in), .rob_tag_in(rob_tag_in), .rs_full_in(rs_full_in), .lsb_full_in(lsb_full_in),
      .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
      .rob_valid_out(rob_valid_out), .rs_valid_out(rs_valid_out), .lsb_valid_out(lsb_valid_out),
      .rob_rd_out(rob_rd_out), .ren_valid_out(ren_valid_out), .ren_rd_out(ren_rd_out), .ren_tag_out(ren_tag_out),
      .iss_op_out(iss_op_out), .iss_dest_out(iss_dest_out),
      .iss_qj_out(iss_qj_out), .iss_vj_out(iss_vj_out), .iss_qk_out(iss_qk_out), .iss_vk_out(iss_vk_out),
      .iss_imm_out(iss_imm_out), .iss_pc_out(iss_pc_out)
   );
   typedef struct {
      logic [5:0] op;
      logic [3:0] dest, qj, qk;
      logic [31:0] vj, vk, imm, pc;
      logic lsb, ren;
      logic [4:0] rd;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int checks = 0;
   int failures = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask
   task automatic expect_issue(input op_t op, input logic [3:0] dest, input logic [3:0] qj, input logic [31:0] vj,
                               input logic [3:0] qk, input logic [31:0] vk, input logic [31:0] imm,
                               input logic [31:0] pc, input logic lsb, input logic [4:0] rd, input logic ren);
      exp_t e;
      e.op = op; e.dest = dest; e.qj = qj; e.vj = vj; e.qk = qk; e.vk = vk;
      e.imm = imm; e.pc = pc; e.lsb = lsb; e.rd = rd; e.ren = ren;
      sb.push_back(e);
   endtask
   task automatic push(input logic [31:0] inst, input logic [31:0] pc);
      @(negedge clk);
      if_valid_in = 1'b1;
      if_inst_in = inst;
      if_pc_in = pc;
      @(negedge clk);
      if_valid_in = 1'b0;
   endtask
   task automatic drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check("drain", 32'(sb.size()), 0);
   endtask
   always @(negedge clk) begin
      if (!rst && (rob_valid_out || rs_valid_out || lsb_valid_out || ren_valid_out)) begin
         check("rob_valid", 32'(rob_valid_out), 1);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue: got op %0d pc %h, expected no issue", iss_op_out, iss_pc_out);
         end else begin
            mon_e = sb.pop_front();
            check("op", 32'(iss_op_out), 32'(mon_e.op));
            check("dest", 32'(iss_dest_out), 32'(mon_e.dest));
            check("qj", 32'(iss_qj_out), 32'(mon_e.qj));
            check("vj", iss_vj_out, mon_e.vj);
            check("qk", 32'(iss_qk_out), 32'(mon_e.qk));
            check("vk", iss_vk_out, mon_e.vk);
            check("imm", iss_imm_out, mon_e.imm);
            check("pc", iss_pc_out, mon_e.pc);
            check("rs_valid", 32'(rs_valid_out), 32'(!mon_e.lsb));
            check("lsb_valid", 32'(lsb_valid_out), 32'(mon_e.lsb));
            check("rob_rd", 32'(rob_rd_out), 32'(mon_e.rd));
            check("ren_valid", 32'(ren_valid_out), 32'(mon_e.ren));
            check("ren_rd", 32'(ren_rd_out), mon_e.ren ? 32'(mon_e.rd) : 0);
            check("ren_tag", 32'(ren_tag_out), mon_e.ren ? 32'(mon_e.dest) : 0);
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_val[i] = 32'h0;
         rf_tag[i] = 4'h0;
      end
      for (int i = 0; i < 16; i++) begin
         rob_rdy[i] = 1'b0;
         rob_dat[i] = 32'h0;
      end
      rst = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; if_valid_in = 1'b0; if_inst_in = '0; if_pc_in = '0;
      rob_full_in = 1'b0; rob_tag_in = 4'd3; rs_full_in = 1'b0; lsb_full_in = 1'b0;
      cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_data_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_rob_valid", 32'(rob_valid_out), 0);
      check("rst_op", 32'(iss_op_out), 0);
      check("rst_dest", 32'(iss_dest_out), 0);
      check("rst_imm", iss_imm_out, 0);
      check("rst_if_ready", 32'(if_ready_out), 1);
      // ADDI x1,x0,5: two-cycle push-to-strobe latency
      expect_issue(OP_ADDI, 4'd3, 4'd0, 0, 4'd0, 0, 32'd5, 32'h100, 1'b0, 5'd1, 1'b1);
      push(32'h00500093, 32'h100);
      check("lat_early", 32'(rs_valid_out), 0);
      @(negedge clk);
      check("lat", 32'(rs_valid_out), 1);
      drain();
      // SW x2,8(x1) with x1 waiting on ROB tag 3
      rf_tag[1] = 4'd3;
      rf_val[2] = 32'h22;
      rob_tag_in = 4'd4;
      expect_issue(OP_SW, 4'd4, 4'd3, 0, 4'd0, 32'h22, 32'd8, 32'h104, 1'b1, 5'd0, 1'b0);
      push(32'h0020A423, 32'h104);
      drain();
      // SRAI x5,x6,3 (x6 ready in ROB), LUI x7,0xFFFFF, BEQ x0,x0,-8
      rf_tag[6] = 4'd6;
      rob_rdy[6] = 1'b1;
      rob_dat[6] = 32'h66;
      rob_tag_in = 4'd8;
      expect_issue(OP_SRAI, 4'd8, 4'd0, 32'h66, 4'd0, 32'd3, 32'h403, 32'h200, 1'b0, 5'd5, 1'b1);
      push(32'h40335293, 32'h200);
      expect_issue(OP_LUI, 4'd8, 4'd0, 0, 4'd0, 0, 32'hFFFFF000, 32'h204, 1'b0, 5'd7, 1'b1);
      push(32'hFFFFF3B7, 32'h204);
      expect_issue(OP_BEQ, 4'd8, 4'd0, 0, 4'd0, 0, 32'hFFFFFFF8, 32'h208, 1'b0, 5'd0, 1'b0);
      push(32'hFE000CE3, 32'h208);
      drain();
      // unknown opcode is dropped; ROB full stalls issue
      rob_full_in = 1'b1;
      rob_tag_in = 4'd10;
      push(32'h0000007F, 32'h280);
      expect_issue(OP_ADDI, 4'd10, 4'd0, 0, 4'd0, 0, 32'hFFFFFFFF, 32'h284, 1'b0, 5'd3, 1'b1);
      push(32'hFFF00193, 32'h284);
      repeat (3) begin
         @(negedge clk);
         check("robfull_block", 32'(rob_valid_out), 0);
      end
      rob_full_in = 1'b0;
      drain();
      // fill the queue behind a full RS, then release for a back-to-back burst
      rs_full_in = 1'b1;
      rob_tag_in = 4'd7;
      for (int k = 1; k <= 8; k++) begin
         expect_issue(OP_ADDI, 4'd7, 4'd0, 0, 4'd0, 0, 32'(k), 32'h300 + 32'(4 * k), 1'b0, 5'(k), 1'b1);
         push((32'(k) << 20) | (32'(k) << 7) | 32'h13, 32'h300 + 32'(4 * k));
         if (k == 7) check("iq_ready7", 32'(if_ready_out), 1);
      end
      check("iq_full", 32'(if_ready_out), 0);
      push(32'h00900493, 32'h340);
      check("iq_full9", 32'(if_ready_out), 0);
      rs_full_in = 1'b0;
      repeat (8) begin
         @(negedge clk);
         check("burst", 32'(rs_valid_out), 1);
      end
      @(negedge clk);
      check("burst_end", 32'(rs_valid_out), 0);
      drain();
      // clear with 4 queued and a same-cycle push
      rs_full_in = 1'b1;
      for (int k = 1; k <= 4; k++) push(32'h00100093, 32'h400 + 32'(4 * k));
      @(negedge clk);
      clear_in = 1'b1;
      if_valid_in = 1'b1;
      if_inst_in = 32'h00200113;
      if_pc_in = 32'h480;
      @(negedge clk);
      clear_in = 1'b0;
      if_valid_in = 1'b0;
      check("clr_op", 32'(iss_op_out), 0);
      check("clr_pc", iss_pc_out, 0);
      rs_full_in = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("clr_nostrobe", 32'(rob_valid_out), 0);
      end
      rob_tag_in = 4'd12;
      expect_issue(OP_ADDI, 4'd12, 4'd0, 0, 4'd0, 0, 32'd4, 32'h500, 1'b0, 5'd4, 1'b1);
      push(32'h00400213, 32'h500);
      drain();
      // ADDI x9,x10,0 with x10 pending on tag 5 while the CDB broadcasts tag 5
      rf_tag[10] = 4'd5;
      rf_val[10] = 32'hAA;
      rob_tag_in = 4'd13;
      cdb_valid_in = 1'b1;
      cdb_tag_in = 4'd5;
      cdb_data_in = 32'h55;
`ifdef CDB_BYPASS_EN
      expect_issue(OP_ADDI, 4'd13, 4'd0, 32'h55, 4'd0, 0, 32'd0, 32'h600, 1'b0, 5'd9, 1'b1);
`else
      expect_issue(OP_ADDI, 4'd13, 4'd5, 0, 4'd0, 0, 32'd0, 32'h600, 1'b0, 5'd9, 1'b1);
`endif
      push(32'h00050493, 32'h600);
      drain();
      cdb_valid_in = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
